// File: rtl/kcpsmx_idu_stage.sv
// kcpsmx_idu_stage -- instruction decode stage for the KCPSMx core.
//
// This file holds the instruction-format package and the decode stage.
// The stage takes a fetched 18-bit word and decodes every union view at
// once, whatever the opcode. It registers the decoded entry with a one-cycle
// latency. A skid register behind the output entry lets in_ready come
// straight from a flop.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             drop both held entries, prev tracking and this cycle's input
//   in_valid/in_ready input handshake; in_instruction, in_pc
//   out_valid/out_ready output handshake; out_pc plus decoded fields:
//     operation, shift_operation, shift_direction, shift_constant,
//     operand_selection, conditional, condition_flags, interrupt_enable,
//     x_address, y_address, implied_value, port_address, scratch_address,
//     code_address, writes_x, raw_hazard

package kcpsmx_idu_pkg;

  typedef enum logic [4:0] {
    OP_LOAD      = 5'd0,
    OP_AND       = 5'd1,
    OP_OR        = 5'd2,
    OP_XOR       = 5'd3,
    OP_ADD       = 5'd4,
    OP_ADDCY     = 5'd5,
    OP_SUB       = 5'd6,
    OP_SUBCY     = 5'd7,
    OP_COMPARE   = 5'd8,
    OP_TEST      = 5'd9,
    OP_SHIFT     = 5'd10,
    OP_INPUT     = 5'd11,
    OP_OUTPUT    = 5'd12,
    OP_FETCH     = 5'd13,
    OP_STORE     = 5'd14,
    OP_JUMP      = 5'd15,
    OP_CALL      = 5'd16,
    OP_RETURN    = 5'd17,
    OP_RETURNI   = 5'd18,
    OP_INTERRUPT = 5'd19
  } opcode_t;

  // Fill source for shifts; SH_ROTATE feeds back the bit shifted out.
  typedef enum logic [1:0] {
    SH_FILL0  = 2'd0,
    SH_FILL1  = 2'd1,
    SH_ARITH  = 2'd2,
    SH_ROTATE = 2'd3
  } shift_op_t;

  // [1] = test carry, [0] = test zero
  typedef logic [1:0] cond_flag_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] pad;
  } reg_reg_t;

  typedef struct packed {
    logic [3:0] x;
    logic [7:0] constant;
  } reg_const_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] pad;
    logic       direction;
    shift_op_t  op;
    logic       constant;
  } shift_t;

  typedef struct packed {
    cond_flag_t flags;
    logic [9:0] address;
  } jump_t;

  typedef struct packed {
    logic [3:0] x;
    logic [7:0] port;
  } port_t;

  typedef struct packed {
    logic [3:0] x;
    logic [1:0] pad;
    logic [5:0] address;
  } scratch_t;

  typedef struct packed {
    logic [10:0] pad;
    logic        enable;
  } interrupt_t;

  typedef union packed {
    reg_reg_t   reg_reg;
    reg_const_t reg_const;
    shift_t     shift;
    jump_t      jump;
    port_t      port;
    scratch_t   scratch;
    interrupt_t interrupt;
  } kcpsmx3_inc;

  typedef struct packed {
    opcode_t    opcode;
    logic       op_cond_sel;
    kcpsmx3_inc inc;
  } instr_t;

endpackage

module kcpsmx_idu_stage
  import kcpsmx_idu_pkg::*;
#(
  parameter int INSTR_WIDTH    = 18,
  parameter int REGISTER_DEPTH = 4,
  parameter int OPERAND_WIDTH  = 8,
  parameter int PORT_DEPTH     = 8,
  parameter int SCRATCH_DEPTH  = 6,
  parameter int CODE_DEPTH     = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  instr_t                    in_instruction,
  input  logic [CODE_DEPTH-1:0]     in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CODE_DEPTH-1:0]     out_pc,
  output opcode_t                   operation,
  output shift_op_t                 shift_operation,
  output logic                      shift_direction,
  output logic                      shift_constant,
  output logic                      operand_selection,
  output logic                      conditional,
  output cond_flag_t                condition_flags,
  output logic                      interrupt_enable,
  output logic [REGISTER_DEPTH-1:0] x_address,
  output logic [REGISTER_DEPTH-1:0] y_address,
  output logic [OPERAND_WIDTH-1:0]  implied_value,
  output logic [PORT_DEPTH-1:0]     port_address,
  output logic [SCRATCH_DEPTH-1:0]  scratch_address,
  output logic [CODE_DEPTH-1:0]     code_address,
  output logic                      writes_x,
  output logic                      raw_hazard
);

  typedef struct packed {
    logic [CODE_DEPTH-1:0]     pc;
    opcode_t                   operation;
    shift_op_t                 shift_operation;
    logic                      shift_direction;
    logic                      shift_constant;
    logic                      op_cond_sel;
    cond_flag_t                condition_flags;
    logic                      interrupt_enable;
    logic [REGISTER_DEPTH-1:0] x;
    logic [REGISTER_DEPTH-1:0] y;
    logic [OPERAND_WIDTH-1:0]  implied;
    logic [PORT_DEPTH-1:0]     port;
    logic [SCRATCH_DEPTH-1:0]  scratch;
    logic [CODE_DEPTH-1:0]     code;
    logic                      writes_x;
    logic                      raw_hazard;
  } entry_t;

  entry_t                    main_q, skid_q, dec;
  logic                      main_valid, skid_full;
  logic                      prev_valid, prev_writes_x;
  logic [REGISTER_DEPTH-1:0] prev_x;
  logic                      in_fire, out_fire, reads_x;

  assign in_ready = !skid_full;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

  // Decode every union view in parallel; consumers pick by operation.
  always_comb begin
    dec                  = '0;
    dec.pc               = in_pc;
    dec.operation        = in_instruction.opcode;
    dec.op_cond_sel      = in_instruction.op_cond_sel;
    dec.shift_operation  = in_instruction.inc.shift.op;
    dec.shift_direction  = in_instruction.inc.shift.direction;
    dec.shift_constant   = in_instruction.inc.shift.constant;
    dec.condition_flags  = in_instruction.inc.jump.flags;
    dec.interrupt_enable = in_instruction.inc.interrupt.enable;
    dec.x       = REGISTER_DEPTH'(in_instruction.inc.reg_reg.x);
    dec.y       = REGISTER_DEPTH'(in_instruction.inc.reg_reg.y);
    dec.implied = OPERAND_WIDTH'(in_instruction.inc.reg_const.constant);
    dec.port    = PORT_DEPTH'(in_instruction.inc.port.port);
    dec.scratch = SCRATCH_DEPTH'(in_instruction.inc.scratch.address);
    dec.code    = CODE_DEPTH'(in_instruction.inc.jump.address);

    unique case (in_instruction.opcode)
      OP_LOAD, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDCY, OP_SUB, OP_SUBCY,
      OP_SHIFT, OP_INPUT, OP_FETCH: dec.writes_x = 1'b1;
      default:                      dec.writes_x = 1'b0;
    endcase

    // LOAD/INPUT/FETCH only overwrite x; the compare/store family reads x
    // without writing it.
    reads_x = 1'b0;
    unique case (in_instruction.opcode)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDCY, OP_SUB, OP_SUBCY, OP_SHIFT,
      OP_COMPARE, OP_TEST, OP_OUTPUT, OP_STORE: reads_x = 1'b1;
      default:                                  reads_x = 1'b0;
    endcase

    dec.raw_hazard = prev_valid && prev_writes_x &&
                     ((reads_x && dec.x == prev_x) ||
                      (dec.op_cond_sel && dec.y == prev_x));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q        <= '0;
      skid_q        <= '0;
      main_valid    <= 1'b0;
      skid_full     <= 1'b0;
      prev_valid    <= 1'b0;
      prev_writes_x <= 1'b0;
      prev_x        <= '0;
    end else if (flush) begin
      // Payload registers keep their contents; only validity is dropped.
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        prev_valid    <= 1'b1;
        prev_writes_x <= dec.writes_x;
        prev_x        <= dec.x;
      end
      if (!main_valid || out_fire) begin
        // Main slot frees up: the older skid entry goes first. in_ready is low
        // whenever skid is full, so nothing new arrives in that case.
        if (skid_full) begin
          main_q    <= skid_q;
          skid_full <= 1'b0;
        end else if (in_fire) begin
          main_q     <= dec;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_q    <= dec;
        skid_full <= 1'b1;
      end
    end
  end

  assign out_valid         = main_valid;
  assign out_pc            = main_q.pc;
  assign operation         = main_q.operation;
  assign shift_operation   = main_q.shift_operation;
  assign shift_direction   = main_q.shift_direction;
  assign shift_constant    = main_q.shift_constant;
  assign operand_selection = main_q.op_cond_sel;
  assign conditional       = main_q.op_cond_sel;
  assign condition_flags   = main_q.condition_flags;
  assign interrupt_enable  = main_q.interrupt_enable;
  assign x_address         = main_q.x;
  assign y_address         = main_q.y;
  assign implied_value     = main_q.implied;
  assign port_address      = main_q.port;
  assign scratch_address   = main_q.scratch;
  assign code_address      = main_q.code;
  assign writes_x          = main_q.writes_x;
  assign raw_hazard        = main_q.raw_hazard;

endmodule

// File: tb/tb_kcpsmx_idu_stage.sv
// Directed bench for kcpsmx_idu_stage: streaming, skid, hazard, jump/shift
// decode, flush, and reset-with-flush.
module tb_kcpsmx_idu_stage;
  import kcpsmx_idu_pkg::*;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  instr_t     in_instruction;
  logic [9:0] in_pc;
  logic       in_ready, out_valid;
  logic [9:0] out_pc, code_address;
  opcode_t    operation;
  shift_op_t  shift_operation;
  cond_flag_t condition_flags;
  logic       shift_direction, shift_constant, operand_selection, conditional;
  logic       interrupt_enable, writes_x, raw_hazard;
  logic [3:0] x_address, y_address;
  logic [7:0] implied_value, port_address;
  logic [5:0] scratch_address;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kcpsmx_idu_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .operation(operation), .shift_operation(shift_operation),
    .shift_direction(shift_direction), .shift_constant(shift_constant),
    .operand_selection(operand_selection), .conditional(conditional),
    .condition_flags(condition_flags), .interrupt_enable(interrupt_enable),
    .x_address(x_address), .y_address(y_address),
    .implied_value(implied_value), .port_address(port_address),
    .scratch_address(scratch_address), .code_address(code_address),
    .writes_x(writes_x), .raw_hazard(raw_hazard)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive/sample 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic [4:0] op, input logic sel, input logic [11:0] lo);
    logic [17:0] w;
    w = {op, sel, lo};
    return instr_t'(w);
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = mk(5'd0, 1'b0, 12'h000); in_pc = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_operation", operation, 0);
    chk("rst_x", x_address, 0);
    chk("rst_code", code_address, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_wx", writes_x, 0);
    chk("rst_raw", raw_hazard, 0);

    // Streaming: ADD s1,s2 then SUB s3,s4
    out_ready = 1'b1; in_valid = 1'b1;
    in_instruction = mk(OP_ADD, 1'b1, 12'h120); in_pc = 10'h010;
    tick();
    chk("st0_valid", out_valid, 1);
    chk("st0_op", operation, OP_ADD);
    chk("st0_xy", {x_address, y_address}, 8'h12);
    chk("st0_pc", out_pc, 10'h010);
    chk("st0_raw", raw_hazard, 0);
    chk("st0_wx", writes_x, 1);
    in_instruction = mk(OP_SUB, 1'b1, 12'h340); in_pc = 10'h011;
    tick();
    chk("st1_valid", out_valid, 1);
    chk("st1_op", operation, OP_SUB);
    chk("st1_xy", {x_address, y_address}, 8'h34);
    chk("st1_pc", out_pc, 10'h011);
    chk("st1_raw", raw_hazard, 0);
    chk("st1_rdy", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("st_drain", out_valid, 0);

    // Skid: out_ready low, offer LOAD s8, OR s9, XOR sA
    out_ready = 1'b0; in_valid = 1'b1;
    in_instruction = mk(OP_LOAD, 1'b0, 12'h811); in_pc = 10'h020;
    tick();
    chk("sk_a_valid", out_valid, 1);
    chk("sk_a_rdy", in_ready, 1);
    in_instruction = mk(OP_OR, 1'b0, 12'h922); in_pc = 10'h021;
    tick();
    chk("sk_b_rdy", in_ready, 0);
    chk("sk_b_hold_op", operation, OP_LOAD);
    chk("sk_b_hold_imm", implied_value, 8'h11);
    in_instruction = mk(OP_XOR, 1'b0, 12'hA33); in_pc = 10'h022;
    tick();
    chk("sk_c_rdy", in_ready, 0);
    chk("sk_c_hold_op", operation, OP_LOAD);
    chk("sk_c_hold_pc", out_pc, 10'h020);
    out_ready = 1'b1;
    tick();
    chk("sk_d_op", operation, OP_OR);
    chk("sk_d_pc", out_pc, 10'h021);
    chk("sk_d_imm", implied_value, 8'h22);
    chk("sk_d_rdy", in_ready, 1);
    chk("sk_d_raw", raw_hazard, 0);
    in_valid = 1'b0;
    tick();
    chk("sk_drain", out_valid, 0);

    // Hazard: LOAD s5,0x3C then ADD s7,s5 (register operand)
    in_valid = 1'b1;
    in_instruction = mk(OP_LOAD, 1'b0, 12'h53C); in_pc = 10'h030;
    tick();
    chk("hz_load_op", operation, OP_LOAD);
    chk("hz_load_raw", raw_hazard, 0);
    chk("hz_load_imm", implied_value, 8'h3C);
    in_instruction = mk(OP_ADD, 1'b1, 12'h750); in_pc = 10'h031;
    tick();
    chk("hz_add_raw", raw_hazard, 1);
    chk("hz_add_wx", writes_x, 1);
    chk("hz_add_xy", {x_address, y_address}, 8'h75);

    // Conditional JUMP, flags 01, target 0x2A5
    in_instruction = mk(OP_JUMP, 1'b1, 12'h6A5); in_pc = 10'h032;
    tick();
    chk("jp_op", operation, OP_JUMP);
    chk("jp_cond", conditional, 1);
    chk("jp_flags", condition_flags, 2'b01);
    chk("jp_addr", code_address, 10'h2A5);
    chk("jp_wx", writes_x, 0);
    chk("jp_raw", raw_hazard, 0);

    // Shift sB: direction 1, ARITH, constant 1
    in_instruction = mk(OP_SHIFT, 1'b0, 12'hB0D); in_pc = 10'h033;
    tick();
    chk("sh_op", shift_operation, SH_ARITH);
    chk("sh_dir", shift_direction, 1);
    chk("sh_const", shift_constant, 1);
    chk("sh_wx", writes_x, 1);
    in_valid = 1'b0;
    tick();

    // Flush with both entries full and an input offered
    out_ready = 1'b0; in_valid = 1'b1;
    in_instruction = mk(OP_ADD, 1'b1, 12'h230); in_pc = 10'h040;
    tick();
    in_instruction = mk(OP_SUB, 1'b1, 12'h420); in_pc = 10'h041;
    tick();
    chk("fl_full_rdy", in_ready, 0);
    flush = 1'b1;
    in_instruction = mk(OP_XOR, 1'b0, 12'h1FF); in_pc = 10'h042;
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    // Would hazard against SUB s4 had prev survived the flush
    out_ready = 1'b1;
    in_instruction = mk(OP_ADD, 1'b1, 12'h440); in_pc = 10'h043;
    tick();
    chk("fl_next_valid", out_valid, 1);
    chk("fl_next_raw", raw_hazard, 0);
    chk("fl_next_pc", out_pc, 10'h043);
    in_valid = 1'b0;
    tick();
    chk("fl_retain_valid", out_valid, 0);
    chk("fl_retain_op", operation, OP_ADD);

    // Reset and flush together with both entries full
    out_ready = 1'b0; in_valid = 1'b1;
    in_instruction = mk(OP_STORE, 1'b0, 12'h915); in_pc = 10'h050;
    tick();
    in_instruction = mk(OP_OUTPUT, 1'b0, 12'h9AB); in_pc = 10'h051;
    tick();
    chk("rf_full_rdy", in_ready, 0);
    reset = 1'b1; flush = 1'b1;
    in_instruction = mk(OP_AND, 1'b1, 12'hFFF); in_pc = 10'h3FF;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rf_valid", out_valid, 0);
    chk("rf_rdy", in_ready, 1);
    chk("rf_op", operation, 0);
    chk("rf_pc", out_pc, 0);
    chk("rf_xy", {x_address, y_address}, 0);
    chk("rf_imm", implied_value, 0);
    chk("rf_code", code_address, 0);
    chk("rf_wx", writes_x, 0);
    chk("rf_raw", raw_hazard, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kcpsmx_idu_stage.md
KCPSMX_IDU_STAGE -- requirements
Module: kcpsmx_idu_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: `clk` and `reset`.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- INSTR_WIDTH, 18, instruction word width.
- REGISTER_DEPTH, 4, register address bits.
- OPERAND_WIDTH, 8, constant width.
- PORT_DEPTH, 8, port address bits.
- SCRATCH_DEPTH, 6, scratchpad address bits.
- CODE_DEPTH, 10, program address bits.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- flush, in, 1, discard all held and incoming instructions.
- in_valid, in, 1, instruction present.
- in_ready, out, 1, stage can accept.
- in_instruction, in, instr_t, fetched word.
- in_pc, in, CODE_DEPTH, address of the fetched word.
- out_valid, out, 1, decoded entry present.
- out_ready, in, 1, downstream accepts.
- out_pc, out, CODE_DEPTH, carried address.
- operation, out, opcode_t, main operation.
- shift_operation, out, shift_op_t, rotate/shift operation.
- shift_direction, out, 1, shift direction.
- shift_constant, out, 1, shift constant.
- operand_selection, out, 1, operand selection.
- conditional, out, 1, conditional flag.
- condition_flags, out, cond_flag_t, zero/carry condition flags.
- interrupt_enable, out, 1, interrupt enable.
- x_address, out, REGISTER_DEPTH, x source/target.
- y_address, out, REGISTER_DEPTH, y source.
- implied_value, out, OPERAND_WIDTH, constant operand.
- port_address, out, PORT_DEPTH, port address.
- scratch_address, out, SCRATCH_DEPTH, scratchpad address.
- code_address, out, CODE_DEPTH, program address.
- writes_x, out, 1, entry writes register x.
- raw_hazard, out, 1, entry reads the register written by its predecessor.

Function
REQ-004 Field extraction SHALL use the instr_t/kcpsmx3_inc union layouts: reg_reg, reg_const, shift, jump, port, scratch and interrupt; operand_selection and conditional both come from op_cond_sel.
REQ-005 All decoded outputs SHALL be registered; an instruction accepted at edge N SHALL appear on the outputs with out_valid=1 after edge N (1-cycle latency).
REQ-006 Handshakes:
- An input transfer occurs when in_valid && in_ready at a clock edge.
- An output transfer occurs when out_valid && out_ready at a clock edge.
- Outputs SHALL hold stable while out_valid && !out_ready.
REQ-007 The stage SHALL hold two entries: a main register driving the outputs and a skid register.
- in_ready = !skid_full, registered.
- An input accepted while the main entry is stalled goes to the skid register.
- When the main entry transfers, the skid entry moves into main on the same edge.
REQ-008 Throughput SHALL be one instruction per cycle when out_ready is held at 1; ordering SHALL be strict FIFO.
REQ-009 Simultaneous input and output transfers with the skid register empty SHALL replace the main entry, with no bubble.
REQ-010 writes_x SHALL be 1 for the opcodes LOAD, AND, OR, XOR, ADD, ADDCY, SUB, SUBCY, shift/rotate, INPUT and FETCH, and 0 for all others.
REQ-011 raw_hazard SHALL be computed on acceptance against the previously accepted instruction (prev). It is 1 iff all of the following hold:
- prev is valid and prev writes_x;
- AND either the entry reads x (any writes_x opcode other than LOAD/INPUT/FETCH, or COMPARE/TEST/OUTPUT/STORE) and x_address == prev x_address, or operand_selection=1 and y_address == prev x_address.
REQ-012 prev tracking SHALL update on every input transfer, independent of output stalls.
REQ-013 flush SHALL take effect at the next edge:
- both entries and prev tracking are invalidated;
- out_valid=0 and in_ready=1;
- any input presented in the flush cycle is discarded, even if in_valid && in_ready.
REQ-014 Data outputs when out_valid=0 SHALL be don't-care for consumers, but SHALL retain their last value; they are not cleared except by reset.

Reset
REQ-015 On reset at an edge:
- out_valid=0, in_ready=1, skid and prev invalid;
- all decoded outputs, out_pc, writes_x and raw_hazard = 0.
REQ-016 Reset SHALL have priority over flush and over any transfer in the same cycle.
REQ-017 Reset asserted mid-stall SHALL discard both held entries.

Verification
REQ-018 Streaming: feed ADD s1,s2 then SUB s3,s4 back-to-back with out_ready=1.
- Response: outputs appear 1 cycle later in order, no bubbles, raw_hazard=0 on both.
REQ-019 Skid: hold out_ready=0 and feed 3 instructions.
- Response: 2 accepted, then in_ready=0; outputs stable; on out_ready=1 both drain in order and in_ready returns to 1.
REQ-020 Hazard: LOAD s5,0x3C followed by ADD s7,s5 (op_cond_sel=1).
- Response: second entry has raw_hazard=1 and writes_x=1; the LOAD entry has raw_hazard=0.
REQ-021 Jump decode: conditional JUMP with flags=2'b01 and code_address=0x2A5.
- Response: conditional=1, condition_flags=01, code_address=0x2A5, writes_x=0.
REQ-022 Flush/reset: flush with both entries full and in_valid=1.
- Response: next cycle out_valid=0 and in_ready=1; the next instruction has raw_hazard=0.
- Repeat with reset and flush asserted together: all outputs are 0.
